// File: rtl/interval_meter.sv
// Measures the length, in clock cycles, of one high run of `in` after a `put` arm pulse.
// Optional feature: define INTERVAL_METER_SYNC_EN to add a 2-flop input synchronizer.
module interval_meter #(
    parameter int W = 8
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         in,
    input  logic         put,
    output logic [W-1:0] value,
    output logic         valid,
    output logic         over,
    output logic         busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        COUNT = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [W-1:0] CNT_MAX = '1;

    state_t       r_state;
    logic [W-1:0] r_count;
    logic [W-1:0] r_value;
    logic         r_valid;
    logic         r_over;
    logic         r_p;
    logic         w_s;
    logic         w_rise;
    logic         w_fall;

`ifdef INTERVAL_METER_SYNC_EN
    logic r_sync1;
    logic r_sync2;

    // Synchronizer resets high so a high input at reset never looks like a rising edge.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= in;
            r_sync2 <= r_sync1;
        end
    end

    assign w_s = r_sync2;
`else
    assign w_s = in;
`endif

    assign w_rise = w_s & ~r_p;
    assign w_fall = ~w_s & r_p;

    // NOTE: all state updates use non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_count <= '0;
            r_value <= '0;
            r_valid <= 1'b0;
            r_over  <= 1'b0;
            r_p     <= 1'b1;
        end else begin
            r_p <= w_s;
            if (put) begin
                // Arming wins over any same-cycle edge and discards a run in progress.
                r_state <= ARMED;
                r_count <= '0;
                r_value <= '0;
                r_valid <= 1'b0;
                r_over  <= 1'b0;
            end else begin
                case (r_state)
                    ARMED: begin
                        if (w_rise) begin
                            r_state <= COUNT;
                            r_count <= {{(W-1){1'b0}}, 1'b1};
                        end
                    end
                    COUNT: begin
                        if (w_fall) begin
                            r_state <= DONE;
                            r_value <= r_count;
                            r_valid <= 1'b1;
                        end else if (w_s) begin
                            if (r_count == CNT_MAX) begin
                                r_over <= 1'b1;
                            end else begin
                                r_count <= r_count + 1'b1;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign value = r_value;
    assign valid = r_valid;
    assign over  = r_over;
    assign busy  = (r_state == ARMED) || (r_state == COUNT);

endmodule
